// File: rtl/pattern_pwm_multi_pkg.sv
// Shared definitions for the multi-channel pattern PWM generator.
// Covers config register addresses, CTRL bit positions and channel state encodings.
package pattern_pwm_multi_pkg;

  localparam logic [2:0] REG_DUTY  = 3'd0;
  localparam logic [2:0] REG_GAP   = 3'd1;
  localparam logic [2:0] REG_NUM   = 3'd2;
  localparam logic [2:0] REG_PAT   = 3'd3;
  localparam logic [2:0] REG_DELAY = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;

  localparam int CTRL_POL_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } chan_state_e;

endpackage

// File: rtl/pattern_pwm_multi_chan.sv
// One PWM pattern channel: shadow config, active config committed on start,
// DELAY/RUN/GAP sequencer and a registered output stage.
module pattern_pwm_multi_chan
  import pattern_pwm_multi_pkg::*;
#(
  parameter int PAT_W  = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  input  logic              stop,
  output logic              pwm_out,
  output logic              busy,
  output logic              valid
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(PAT_W - 1);
  localparam logic [DATA_W-1:0] CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  chan_state_e state_q, state_d;

  logic [DATA_W-1:0] duty_sh_q, duty_sh_d, gap_sh_q, gap_sh_d;
  logic [DATA_W-1:0] num_sh_q, num_sh_d, delay_sh_q, delay_sh_d;
  logic [PAT_W-1:0]  pat_sh_q, pat_sh_d;
  logic              pol_sh_q, pol_sh_d;

  logic [DATA_W-1:0] duty_q, duty_d, gap_q, gap_d, num_q, num_d, delay_q, delay_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              pol_q, pol_d, started_q, started_d;

  logic [DATA_W-1:0] cnt_q, cnt_d, rep_q, rep_d, rep_inc;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              done_q, done_d;
  logic              pwm_q, pwm_d, busy_q, busy_d, valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      duty_sh_q  <= '0;
      gap_sh_q   <= '0;
      num_sh_q   <= '0;
      delay_sh_q <= '0;
      pat_sh_q   <= '0;
      pol_sh_q   <= 1'b0;
      duty_q     <= '0;
      gap_q      <= '0;
      num_q      <= '0;
      delay_q    <= '0;
      pat_q      <= '0;
      pol_q      <= 1'b0;
      started_q  <= 1'b0;
      cnt_q      <= '0;
      rep_q      <= '0;
      bit_q      <= '0;
      done_q     <= 1'b0;
      pwm_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_sh_q  <= duty_sh_d;
      gap_sh_q   <= gap_sh_d;
      num_sh_q   <= num_sh_d;
      delay_sh_q <= delay_sh_d;
      pat_sh_q   <= pat_sh_d;
      pol_sh_q   <= pol_sh_d;
      duty_q     <= duty_d;
      gap_q      <= gap_d;
      num_q      <= num_d;
      delay_q    <= delay_d;
      pat_q      <= pat_d;
      pol_q      <= pol_d;
      started_q  <= started_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      bit_q      <= bit_d;
      done_q     <= done_d;
      pwm_q      <= pwm_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    duty_sh_d  = duty_sh_q;
    gap_sh_d   = gap_sh_q;
    num_sh_d   = num_sh_q;
    delay_sh_d = delay_sh_q;
    pat_sh_d   = pat_sh_q;
    pol_sh_d   = pol_sh_q;
    if (cfg_we) begin
      case (cfg_addr)
        REG_DUTY:  duty_sh_d  = cfg_wdata;
        REG_GAP:   gap_sh_d   = cfg_wdata;
        REG_NUM:   num_sh_d   = cfg_wdata;
        REG_PAT:   pat_sh_d   = cfg_wdata[PAT_W-1:0];
        REG_DELAY: delay_sh_d = cfg_wdata;
        REG_CTRL:  pol_sh_d   = cfg_wdata[CTRL_POL_BIT];
        default:   ;
      endcase
    end
  end

  // Start samples the registered shadow, so a same-cycle write lands only in the shadow.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    gap_d     = gap_q;
    num_d     = num_q;
    delay_d   = delay_q;
    pat_d     = pat_q;
    pol_d     = pol_q;
    started_d = started_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    bit_d     = bit_q;
    done_d    = 1'b0;
    rep_inc   = (rep_q == CNT_MAX) ? rep_q : rep_q + ONE;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          duty_d    = duty_sh_q;
          gap_d     = gap_sh_q;
          num_d     = num_sh_q;
          delay_d   = delay_sh_q;
          pat_d     = pat_sh_q;
          pol_d     = pol_sh_q;
          started_d = 1'b1;
          cnt_d     = '0;
          rep_d     = '0;
          bit_d     = '0;
          if (duty_sh_q == '0)       state_d = ST_IDLE;
          else if (delay_sh_q != '0) state_d = ST_DELAY;
          else                       state_d = ST_RUN;
        end
      end
      ST_DELAY: begin
        if (cnt_q == delay_q - ONE) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_RUN: begin
        if (cnt_q == duty_q - ONE) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            rep_d = rep_inc;
            if (num_q != '0 && rep_inc == num_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d = ST_GAP;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == gap_q - ONE) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  // Before the first start the idle level follows the shadow polarity.
  always_comb begin
    pwm_d   = pol_q;
    busy_d  = (state_q != ST_IDLE);
    valid_d = done_q;
    case (state_q)
      ST_RUN:  pwm_d = pat_q[bit_q] ^ pol_q;
      ST_IDLE: pwm_d = started_q ? pol_q : pol_sh_q;
      default: pwm_d = pol_q;
    endcase
  end

  assign pwm_out = pwm_q;
  assign busy    = busy_q;
  assign valid   = valid_q;

endmodule

// File: rtl/pattern_pwm_multi.sv
// N-channel pattern PWM generator: decodes the shared config bus into
// per-channel write enables and fans the start/stop strobes out by mask.
module pattern_pwm_multi
  import pattern_pwm_multi_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int PAT_W  = 16,
  parameter int DATA_W = 16,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [2:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  input  logic [N_CH-1:0]   start_mask,
  input  logic              stop,
  input  logic [N_CH-1:0]   stop_mask,
  output logic [N_CH-1:0]   pwm_out,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   valid
);

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    logic we_k;
    assign we_k = cfg_we && (cfg_ch == CH_W'(k));

    pattern_pwm_multi_chan #(
      .PAT_W  (PAT_W),
      .DATA_W (DATA_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (we_k),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .start     (start && start_mask[k]),
      .stop      (stop && stop_mask[k]),
      .pwm_out   (pwm_out[k]),
      .busy      (busy[k]),
      .valid     (valid[k])
    );
  end

endmodule
